// File: rtl/count_controller.sv
// Round sequencer for a downstream countdown stage: launches a countdown, waits
// for its done flag, releases it, waits for the flag to clear, and repeats.
module count_controller #(
    parameter int TIMEOUT = 24
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rounds_cfg,
    input  logic       final_signal,
    input  logic [3:0] count_value,
    output logic       init_signal,
    output logic [3:0] round_cnt,
    output logic [3:0] last_value,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_FINAL = 3'd2,
        RELEASE    = 3'd3,
        WAIT_CLEAR = 3'd4,
        DONE       = 3'd5,
        ERROR      = 3'd6
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic       start_sync_p0;
    logic       start_sync_p1;
    logic       start_hist_p2;
    logic       start_rise;
    state_t     state;
    logic [7:0] timer;
    logic [3:0] target;
    logic [3:0] round_nxt;

    // Stage p0/p1: metastability synchronizer; p2: edge-detect history
    always_ff @(posedge clk_out) begin
        if (reset) begin
            start_sync_p0 <= 1'b0;
            start_sync_p1 <= 1'b0;
            start_hist_p2 <= 1'b0;
        end else begin
            start_sync_p0 <= start;
            start_sync_p1 <= start_sync_p0;
            start_hist_p2 <= start_sync_p1;
        end
    end

    assign start_rise = start_sync_p1 & ~start_hist_p2;
    assign round_nxt  = round_cnt + 4'd1;

    // Status flags and init_signal are set on the transition into a state,
    // so they are plain flops that line up exactly with the state register.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            state       <= IDLE;
            init_signal <= 1'b0;
            round_cnt   <= 4'd0;
            last_value  <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            timer       <= 8'd0;
            target      <= 4'd0;
        end else begin
            init_signal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        round_cnt  <= 4'd0;
                        last_value <= 4'd0;
                        if (rounds_cfg != 4'd0) begin
                            target      <= rounds_cfg;
                            state       <= LAUNCH;
                            init_signal <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    timer <= 8'd0;
                    state <= WAIT_FINAL;
                end
                WAIT_FINAL: begin
                    if (final_signal) begin
                        last_value  <= count_value;
                        state       <= RELEASE;
                        init_signal <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RELEASE: begin
                    timer <= 8'd0;
                    state <= WAIT_CLEAR;
                end
                WAIT_CLEAR: begin
                    if (!final_signal) begin
                        round_cnt <= round_nxt;
                        if (round_nxt == target) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= LAUNCH;
                            init_signal <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE, ERROR: begin
                    if (start_rise) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_controller.sv
// Bench for count_controller: a behavioural countdown stage plus a table of runs
// whose expected outcomes are queued at start and compared when the run ends.
module tb_count_controller;

    localparam int TIMEOUT = 24;

    logic       clk_out;
    logic       reset;
    logic       start;
    logic [3:0] rounds_cfg;
    logic       final_signal;
    logic [3:0] count_value;
    logic       init_signal;
    logic [3:0] round_cnt;
    logic [3:0] last_value;
    logic       busy;
    logic       done;
    logic       error;

    count_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk_out      (clk_out),
        .reset        (reset),
        .start        (start),
        .rounds_cfg   (rounds_cfg),
        .final_signal (final_signal),
        .count_value  (count_value),
        .init_signal  (init_signal),
        .round_cnt    (round_cnt),
        .last_value   (last_value),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    // Countdown model. mode 0: final after model_delay cycles, drops on release.
    // mode 1: final never asserted. mode 2: final stays high after release.
    int         model_mode  = 0;
    int         model_delay = 16;
    logic [3:0] model_fv    = 4'd0;
    logic       model_clr   = 1'b0;
    int         mcnt        = 0;

    always @(posedge clk_out) begin
        if (reset || model_clr) begin
            final_signal <= 1'b0;
            count_value  <= 4'd0;
            mcnt         <= 0;
        end else if (init_signal) begin
            if (!final_signal) begin
                mcnt        <= 1;
                count_value <= 4'hF;
            end else if (model_mode != 2) begin
                final_signal <= 1'b0;
            end
        end else if (mcnt != 0) begin
            if (model_mode != 1 && mcnt == model_delay) begin
                final_signal <= 1'b1;
                count_value  <= model_fv;
                mcnt         <= 0;
            end else begin
                mcnt <= mcnt + 1;
                if (count_value != 4'd0) count_value <= count_value - 4'd1;
            end
        end
    end

    // Output monitor: init pulse count, double-wide pulses, round_cnt steps,
    // and busy cycles since the most recent init pulse.
    int         init_total  = 0;
    int         init_double = 0;
    int         rc_bad      = 0;
    int         wait_cycles = 0;
    logic       prev_init   = 1'b0;
    logic [3:0] prev_rc     = 4'd0;

    always @(negedge clk_out) begin
        if (init_signal === 1'b1) begin
            init_total++;
            wait_cycles = 0;
            if (prev_init) init_double++;
        end else if (busy === 1'b1) begin
            wait_cycles++;
        end
        if (round_cnt != prev_rc && round_cnt != 4'd0 && int'(round_cnt) != int'(prev_rc) + 1)
            rc_bad++;
        prev_init = init_signal;
        prev_rc   = round_cnt;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int rounds;
        int cfg_after;
        int mode;
        int delay;
        int fv;
        int e_done;
        int e_err;
        int e_rc;
        int e_init;
        int e_last;
        int e_wait;
        int e_lat;
    } vec_t;

    typedef struct {
        int e_done;
        int e_err;
        int e_rc;
        int e_init;
        int e_last;
        int e_wait;
        int e_lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_out);
        #1;
    endtask

    // Press start from DONE/ERROR: must land in IDLE without launching a new run.
    task automatic return_idle(input string tag, input int exp_rc);
        int base;
        base      = init_total;
        model_clr = 1'b1;
        start     = 1'b1;
        cyc(1);
        model_clr = 1'b0;
        cyc(2);
        start = 1'b0;
        cyc(5);
        check({tag, " idle done"},  int'(done), 0);
        check({tag, " idle error"}, int'(error), 0);
        check({tag, " idle busy"},  int'(busy), 0);
        check({tag, " idle rc"},    int'(round_cnt), exp_rc);
        check({tag, " idle inits"}, init_total - base, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t  e;
        int    base, dbl_base, rcb_base, lat;
        bit    seen;
        string tag;
        tag         = $sformatf("v%0d", idx);
        model_mode  = v.mode;
        model_delay = v.delay;
        model_fv    = 4'(v.fv);
        rounds_cfg  = 4'(v.rounds);
        base        = init_total;
        dbl_base    = init_double;
        rcb_base    = rc_bad;
        start       = 1'b1;
        e.e_done = v.e_done; e.e_err = v.e_err; e.e_rc = v.e_rc; e.e_init = v.e_init;
        e.e_last = v.e_last; e.e_wait = v.e_wait; e.e_lat = v.e_lat;
        sb.push_back(e);
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            cyc(1);
            lat++;
            if (lat == 3) start = 1'b0;
            if (lat == 4) rounds_cfg = 4'(v.cfg_after);
            if (done === 1'b1 || error === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) check({tag, " end-of-run timeout"}, 0, 1);
        e = sb.pop_front();
        check({tag, " done"},   int'(done), e.e_done);
        check({tag, " error"},  int'(error), e.e_err);
        check({tag, " rc"},     int'(round_cnt), e.e_rc);
        check({tag, " last"},   int'(last_value), e.e_last);
        check({tag, " inits"},  init_total - base, e.e_init);
        check({tag, " busy"},   int'(busy), 0);
        check({tag, " init"},   int'(init_signal), 0);
        check({tag, " pulse width"}, init_double - dbl_base, 0);
        check({tag, " rc steps"},    rc_bad - rcb_base, 0);
        if (e.e_wait >= 0) check({tag, " wait cycles"}, wait_cycles, e.e_wait);
        if (e.e_lat > 0)   check({tag, " latency ok"}, int'(lat <= e.e_lat), 1);
        cyc(5);
        check({tag, " hold done"},  int'(done), e.e_done);
        check({tag, " hold error"}, int'(error), e.e_err);
        check({tag, " hold inits"}, init_total - base, e.e_init);
        return_idle(tag, e.e_rc);
    endtask

    initial begin
        int  base;
        bit  seen;
        reset      = 1'b1;
        start      = 1'b0;
        rounds_cfg = 4'd0;

        //        rounds after mode dly fv  done err rc init last wait     lat
        vecs[0] = '{3,     3,    0,   16, 0,  1,   0,  3,  6,   0,   -1,      0};
        vecs[1] = '{2,     2,    1,   0,  0,  0,   1,  0,  1,   0,   TIMEOUT, 0};
        vecs[2] = '{2,     2,    0,   24, 3,  0,   1,  0,  1,   0,   TIMEOUT, 0};
        vecs[3] = '{0,     0,    0,   16, 0,  1,   0,  0,  0,   0,   -1,      4};
        vecs[4] = '{1,     1,    2,   2,  7,  0,   1,  0,  2,   7,   TIMEOUT, 0};
        vecs[5] = '{1,     5,    0,   1,  9,  1,   0,  1,  2,   9,   -1,      0};
        vecs[6] = '{15,    2,    0,   3,  15, 1,   0,  15, 30,  15,  -1,      0};
        vecs[7] = '{2,     0,    0,   23, 5,  1,   0,  2,  4,   5,   -1,      0};

        cyc(3);
        check("reset init",  int'(init_signal), 0);
        check("reset rc",    int'(round_cnt), 0);
        check("reset last",  int'(last_value), 0);
        check("reset busy",  int'(busy), 0);
        check("reset done",  int'(done), 0);
        check("reset error", int'(error), 0);
        reset = 1'b0;
        cyc(3);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Start held for 50 cycles, then a second press while the run is busy.
        model_mode  = 0;
        model_delay = 16;
        model_fv    = 4'd0;
        rounds_cfg  = 4'd3;
        base        = init_total;
        seen        = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            start = (i < 50) || (i >= 52 && i < 55);
            if (i == 53) check("held second press busy", int'(busy), 1);
            cyc(1);
            if (i >= 55 && (done === 1'b1 || error === 1'b1)) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) check("held end-of-run timeout", 0, 1);
        check("held done",  int'(done), 1);
        check("held rc",    int'(round_cnt), 3);
        check("held inits", init_total - base, 6);
        cyc(20);
        check("held no restart inits", init_total - base, 6);
        check("held no restart done",  int'(done), 1);
        return_idle("held", 3);

        // Reset during WAIT_FINAL of round 2 of a 4-round run.
        rounds_cfg = 4'd4;
        base       = init_total;
        start      = 1'b1;
        cyc(3);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            cyc(1);
            if (init_total - base >= 3) seen = 1'b1;
        end
        if (!seen) check("abort launch timeout", 0, 1);
        cyc(4);
        check("abort pre rc",   int'(round_cnt), 1);
        check("abort pre busy", int'(busy), 1);
        reset = 1'b1;
        cyc(1);
        check("abort init",  int'(init_signal), 0);
        check("abort rc",    int'(round_cnt), 0);
        check("abort last",  int'(last_value), 0);
        check("abort busy",  int'(busy), 0);
        check("abort done",  int'(done), 0);
        check("abort error", int'(error), 0);
        reset = 1'b0;
        cyc(30);
        check("abort no pulse", init_total - base, 3);
        check("abort stays idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
